// File: rtl/freq_gen_pkg.sv
// Shared types and helpers for the freq_gen square-wave generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package freq_gen_pkg;

  localparam int unsigned WINDOW_DEF = 100000;
  localparam int unsigned CNT_W_DEF  = 32;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_RUN   = RUN,
    S_DRAIN = DRAIN
  } state_e;

  // Highest reachable frequency is one full period every two clocks, so any
  // request above half the window is limited to exactly that.
  function automatic logic [63:0] clamp_freq(input logic [63:0] f,
                                             input logic [63:0] window);
    logic [63:0] half;
    half = window >> 1;
    return (f > half) ? half : f;
  endfunction

endpackage

// File: rtl/freq_gen_phase_acc.sv
// Phase accumulator: adds incr each step, wraps modulo WINDOW, flags a wrap.
// Latency: toggle is combinational from the current accumulator and incr.
// Backpressure: none; advances whenever step is high, clear has priority.
//
// Ports: clk, rst_n (async active-low), clear (zero the accumulator),
//        step (advance one cycle), incr (2*F_eff), toggle (wrap this cycle).
module freq_gen_phase_acc
  import freq_gen_pkg::*;
#(
  parameter int unsigned WINDOW = WINDOW_DEF,
  parameter int unsigned ACC_W  = CNT_W_DEF + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  input  logic [ACC_W-1:0] incr,
  output logic             toggle
);

  localparam logic [ACC_W-1:0] WIN_V = ACC_W'(WINDOW);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             wrap;

  // acc stays below WINDOW and incr never exceeds WINDOW, so sum fits and
  // a single subtraction is enough to bring it back into range.
  always_comb begin
    sum    = acc + incr;
    wrap   = (sum >= WIN_V);
    toggle = step && wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= wrap ? (sum - WIN_V) : sum;
    end
  end

endmodule

// File: rtl/freq_gen.sv
// Square-wave generator: exactly F periods per WINDOW-cycle gate window.
// Latency: config applies at the next window start; sig_out is registered.
// Backpressure: one pending-config slot; cfg_ready low while it is occupied.
//
// Ports: clk, rst_n (async active-low), enable (level run request),
//        cfg_freq/cfg_valid/cfg_ready (frequency config handshake),
//        sig_out (generated wave), window_tick (last cycle of a window),
//        active_freq (clamped F of the current window), busy (not idle).
// Optional: define FREQ_GEN_EDGE_CNT_EN to add edge_count, the number of
//        rising edges produced in the most recently completed window.
module freq_gen
  import freq_gen_pkg::*;
#(
  parameter int unsigned WINDOW = WINDOW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] cfg_freq,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             sig_out,
  output logic             window_tick,
  output logic [CNT_W-1:0] active_freq,
`ifdef FREQ_GEN_EDGE_CNT_EN
  output logic [CNT_W-1:0] edge_count,
`endif
  output logic             busy
);

  localparam int unsigned WC_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned ACC_W = CNT_W + 1;

  state_e           state;
  state_e           state_nxt;
  logic [WC_W-1:0]  win_cnt;
  logic             pend_vld;
  logic [CNT_W-1:0] pend_dat;
  logic             cfg_accept;
  logic             win_start;
  logic             apply;
  logic             acc_clear;
  logic             acc_step;
  logic             toggle;

  assign cfg_ready   = !pend_vld;
  assign busy        = (state != S_IDLE);
  assign window_tick = busy && (win_cnt == WC_W'(WINDOW - 1));
  assign cfg_accept  = cfg_valid && !pend_vld;

  // A new window begins after the tick when running continues, or on the
  // first cycle out of IDLE. A window that ends with enable low goes idle
  // and leaves any pending config for the next start.
  assign win_start = enable && ((state == S_IDLE) || window_tick);
  assign apply     = win_start && pend_vld;
  assign acc_step  = busy;
  assign acc_clear = (state == S_IDLE) || apply;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_RUN;
      end
      default: begin
        // Dropping enable only ever finishes the current window.
        if (window_tick && !enable) state_nxt = S_IDLE;
        else                        state_nxt = enable ? S_RUN : S_DRAIN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (!busy || window_tick) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + WC_W'(1);
    end
  end

  // Accept and apply never coincide: accept needs an empty slot, apply a
  // full one, so a config taken in the tick cycle waits a whole window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld    <= 1'b0;
      pend_dat    <= '0;
      active_freq <= '0;
    end else begin
      if (cfg_accept) begin
        pend_vld <= 1'b1;
        pend_dat <= cfg_freq;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
      if (apply) begin
        active_freq <= CNT_W'(clamp_freq(64'(pend_dat), 64'(WINDOW)));
      end
    end
  end

  freq_gen_phase_acc #(
    .WINDOW (WINDOW),
    .ACC_W  (ACC_W)
  ) u_phase_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (acc_clear),
    .step   (acc_step),
    .incr   ({active_freq, 1'b0}),
    .toggle (toggle)
  );

  // The last wrap of a window lands in its tick cycle, so the wave is back
  // low exactly when the next window starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_out <= 1'b0;
    end else if (!busy) begin
      sig_out <= 1'b0;
    end else begin
      sig_out <= sig_out ^ toggle;
    end
  end

`ifdef FREQ_GEN_EDGE_CNT_EN
  logic [CNT_W-1:0] rise_cnt;
  logic             rise_now;

  // A toggle while low is a rising edge one cycle later; counting it here
  // lets the tick cycle include its own edge in the window total.
  assign rise_now = toggle && !sig_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt   <= '0;
      edge_count <= '0;
    end else if (window_tick) begin
      rise_cnt   <= '0;
      edge_count <= rise_cnt + CNT_W'(rise_now);
    end else begin
      rise_cnt   <= rise_cnt + CNT_W'(rise_now);
    end
  end
`endif

endmodule
